// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline register.
//   state_t          : occupancy state (empty, one entry, two entries)
//   NOP_WORD_DEFAULT : payload shown while the register holds nothing
//   sat_inc          : saturating add of 0..2, used by the perf counters
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'hE000_0000;

    // Works on 32-bit containers; 'max' is the all-ones value of the real
    // counter width. The headroom test avoids wrapping even at 32 bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                            input logic [1:0]  inc,
                                            input logic [31:0] max);
        if ((max - cnt) < {30'd0, inc})
            return max;
        return cnt + {30'd0, inc};
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating performance counter.
//   clk, rst : clock, async active-high reset (clears count)
//   inc      : amount to add this cycle (0..2)
//   cnt      : current count, sticks at all-ones
module sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [31:0] MAX = 32'({CNT_W{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= CNT_W'(sat_inc(32'(cnt), inc, MAX));
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register (PC + payload) with valid/ready handshake,
// optional 2-entry skid buffer, flush/freeze control and perf counters.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : upstream handshake; in_pc/in_data upstream entry
//   flush               : drop every held entry and any same-cycle enqueue
//   freeze              : hold the head, block dequeue (enqueue still allowed)
//   out_valid/out_ready : downstream handshake; out_pc/out_data head entry
//   stall_cnt           : cycles with a valid head that did not dequeue
//   flush_cnt           : valid entries discarded by flush
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                PC_W     = 32,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT),
    parameter bit                SKID     = 1'b1,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    input  logic              freeze,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    state_t            state, state_n;
    logic [PC_W-1:0]   head_pc, head_pc_n, skid_pc, skid_pc_n;
    logic [DATA_W-1:0] head_data, head_data_n, skid_data, skid_data_n;
    logic              enq, deq;
    logic [1:0]        stall_inc, flush_inc;

    assign out_valid = (state != ST_EMPTY);
    assign out_pc    = head_pc;
    assign out_data  = head_data;

    assign deq = out_valid & out_ready & ~freeze;

    // With the skid buffer in_ready depends on registered state only, which
    // breaks the combinational ready chain across stages. Without it the
    // single entry can be replaced in the cycle it leaves.
    assign in_ready = SKID ? (state != ST_SKID) : (~out_valid | deq);
    assign enq      = in_valid & in_ready;

    always_comb begin
        state_n     = state;
        head_pc_n   = head_pc;
        head_data_n = head_data;
        skid_pc_n   = skid_pc;
        skid_data_n = skid_data;
        if (flush) begin
            state_n     = ST_EMPTY;
            head_pc_n   = '0;
            head_data_n = NOP_WORD;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (enq) begin
                        state_n     = ST_FULL;
                        head_pc_n   = in_pc;
                        head_data_n = in_data;
                    end
                end
                ST_FULL: begin
                    if (enq && deq) begin
                        head_pc_n   = in_pc;
                        head_data_n = in_data;
                    end else if (enq) begin
                        // only reachable with SKID=1 (in_ready is low otherwise)
                        state_n     = ST_SKID;
                        skid_pc_n   = in_pc;
                        skid_data_n = in_data;
                    end else if (deq) begin
                        state_n     = ST_EMPTY;
                        head_pc_n   = '0;
                        head_data_n = NOP_WORD;
                    end
                end
                ST_SKID: begin
                    if (deq) begin
                        state_n     = ST_FULL;
                        head_pc_n   = skid_pc;
                        head_data_n = skid_data;
                    end
                end
                default: state_n = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_EMPTY;
            head_pc   <= '0;
            head_data <= NOP_WORD;
            skid_pc   <= '0;
            skid_data <= NOP_WORD;
        end else begin
            state     <= state_n;
            head_pc   <= head_pc_n;
            head_data <= head_data_n;
            skid_pc   <= skid_pc_n;
            skid_data <= skid_data_n;
        end
    end

    // A flushed cycle with a valid head still counts as a stall: nothing left.
    assign stall_inc = {1'b0, out_valid & ~deq};

    always_comb begin
        flush_inc = 2'd0;
        if (flush) begin
            case (state)
                ST_FULL: flush_inc = 2'd1;
                ST_SKID: flush_inc = 2'd2;
                default: flush_inc = 2'd0;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam logic [31:0] NOP = 32'hE000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, freeze, out_ready;
    logic [31:0] in_pc, in_data;
    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_data;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_pc, s_out_data;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int   errors = 0;
    int   checks = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;
    ent_t sb[$];
    ent_t e;

    always #5 clk = ~clk;

    pipe_stage_reg #(.SKID(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_data(in_data), .flush(flush), .freeze(freeze),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_data(out_data), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter copy driven by the same stimulus, for saturation.
    pipe_stage_reg #(.SKID(1'b1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_pc(in_pc), .in_data(in_data), .flush(flush), .freeze(freeze),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_out_pc),
        .out_data(s_out_data), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    function automatic logic [31:0] dat(input logic [31:0] pc);
        return pc ^ 32'hA5A5_5A5A;
    endfunction

    // Inputs are changed right after a falling edge; outputs are read at
    // the falling edge, half a cycle away from the active edge.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        in_valid = v;
        in_pc    = pc;
        in_data  = dat(pc);
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_data = '0;
        flush = 1'b0; freeze = 1'b0; out_ready = 1'b0;
        tick;
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_data !== NOP) begin errors++; $display("FAIL reset_out: valid=%b pc=%h data=%h want 0/0/%h", out_valid, out_pc, out_data, NOP); end
        checks++; if (in_ready !== 1'b1 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_misc: in_ready=%b stall=%0d flush=%0d want 1/0/0", in_ready, stall_cnt, flush_cnt); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_stream;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(i * 4));
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready); end
            sb.push_back({in_pc, in_data});
            tick;
            e = sb.pop_front();
            checks++; if (out_valid !== 1'b1 || out_pc !== e.pc || out_data !== e.data) begin errors++; $display("FAIL stream_out[%0d]: valid=%b pc=%h data=%h want 1/%h/%h", i, out_valid, out_pc, out_data, e.pc, e.data); end
        end
        drive(1'b0, 32'h0);
        tick;
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_data !== NOP) begin errors++; $display("FAIL stream_drain: valid=%b pc=%h data=%h want 0/0/%h", out_valid, out_pc, out_data, NOP); end
        checks++; if (int'(stall_cnt) !== exp_stall) begin errors++; $display("FAIL stream_stall: got %0d want %0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive(1'b1, 32'h10);
        sb.push_back({in_pc, in_data});
        tick;
        drive(1'b1, 32'h14);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_full: got %b want 1", in_ready); end
        sb.push_back({in_pc, in_data});
        tick; exp_stall++;
        checks++; if (in_ready !== 1'b0 || out_pc !== 32'h10) begin errors++; $display("FAIL bp_skid: in_ready=%b pc=%h want 0/10", in_ready, out_pc); end
        drive(1'b1, 32'h18);            // refused: buffer full
        tick; exp_stall++;
        checks++; if (int'(stall_cnt) !== exp_stall || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold: stall=%0d in_ready=%b want %0d/0", stall_cnt, in_ready, exp_stall); end
        drive(1'b0, 32'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            e = sb[0];
            checks++; if (out_valid !== 1'b1 || out_pc !== e.pc || out_data !== e.data) begin errors++; $display("FAIL bp_order[%0d]: pc=%h data=%h want %h/%h", i, out_pc, out_data, e.pc, e.data); end
            tick;
            void'(sb.pop_front());
        end
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || int'(stall_cnt) !== exp_stall) begin errors++; $display("FAIL bp_drain: valid=%b in_ready=%b stall=%0d want 0/1/%0d", out_valid, in_ready, stall_cnt, exp_stall); end
    endtask

    task automatic test_freeze;
        out_ready = 1'b1;
        drive(1'b1, 32'h20);
        sb.push_back({in_pc, in_data});
        tick;
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                drive(1'b1, 32'h24);
                sb.push_back({in_pc, in_data});
            end else begin
                drive(1'b0, 32'h0);
            end
            tick; exp_stall++;
            checks++; if (out_pc !== 32'h20 || out_valid !== 1'b1) begin errors++; $display("FAIL freeze_hold[%0d]: pc=%h valid=%b want 20/1", i, out_pc, out_valid); end
        end
        checks++; if (int'(stall_cnt) !== exp_stall || in_ready !== 1'b0) begin errors++; $display("FAIL freeze_cnt: stall=%0d in_ready=%b want %0d/0", stall_cnt, in_ready, exp_stall); end
        freeze = 1'b0;
        void'(sb.pop_front());
        tick;
        e = sb.pop_front();
        checks++; if (out_pc !== e.pc || out_data !== e.data) begin errors++; $display("FAIL freeze_resume: pc=%h data=%h want %h/%h", out_pc, out_data, e.pc, e.data); end
        tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL freeze_drain: valid=%b want 0", out_valid); end
    endtask

    // Fills the register to two entries with out_ready low.
    task automatic fill_two(input logic [31:0] base);
        out_ready = 1'b0;
        drive(1'b1, base);
        tick;
        drive(1'b1, base + 32'h4);
        tick; exp_stall++;
    endtask

    task automatic test_flush;
        for (int k = 0; k < 2; k++) begin
            fill_two(32'h30 + 32'(k * 16));
            freeze    = (k == 1);
            out_ready = (k == 1);
            flush     = 1'b1;
            drive(1'b1, 32'h38 + 32'(k * 16));
            tick; exp_stall++; exp_flush += 2;
            flush = 1'b0; freeze = 1'b0;
            checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_data !== NOP || in_ready !== 1'b1) begin errors++; $display("FAIL flush_empty[%0d]: valid=%b pc=%h data=%h in_ready=%b want 0/0/%h/1", k, out_valid, out_pc, out_data, in_ready, NOP); end
            checks++; if (int'(flush_cnt) !== exp_flush || int'(stall_cnt) !== exp_stall) begin errors++; $display("FAIL flush_cnt[%0d]: flush=%0d stall=%0d want %0d/%0d", k, flush_cnt, stall_cnt, exp_flush, exp_stall); end
            drive(1'b0, 32'h0);
            tick;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop[%0d]: valid=%b want 0", k, out_valid); end
        end
        // one held entry counts 1; flushing an empty block counts 0
        out_ready = 1'b0;
        drive(1'b1, 32'h50);
        tick;
        flush = 1'b1;
        drive(1'b0, 32'h0);
        tick; exp_stall++; exp_flush += 1;
        drive(1'b1, 32'h54);
        tick;
        flush = 1'b0;
        drive(1'b0, 32'h0);
        checks++; if (int'(flush_cnt) !== exp_flush || out_valid !== 1'b0) begin errors++; $display("FAIL flush_single: flush=%0d valid=%b want %0d/0", flush_cnt, out_valid, exp_flush); end
    endtask

    task automatic test_reset_midstream;
        fill_two(32'h70);
        drive(1'b0, 32'h0);
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_data !== NOP || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_out: valid=%b pc=%h data=%h in_ready=%b want 0/0/%h/1", out_valid, out_pc, out_data, in_ready, NOP); end
        checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_cnt: stall=%0d flush=%0d want 0/0", stall_cnt, flush_cnt); end
        @(negedge clk);
        rst = 1'b0;
        exp_stall = 0; exp_flush = 0;
        sb.delete();
        tick;
    endtask

    task automatic test_saturation;
        out_ready = 1'b0;
        drive(1'b1, 32'h60);
        tick;
        drive(1'b0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            tick; exp_stall++;
            if (i == 1) begin
                checks++; if (s_stall_cnt !== 2'd2) begin errors++; $display("FAIL sat_mid: got %0d want 2", s_stall_cnt); end
            end
        end
        checks++; if (s_stall_cnt !== 2'd3) begin errors++; $display("FAIL sat_stick: got %0d want 3", s_stall_cnt); end
        checks++; if (int'(stall_cnt) !== exp_stall) begin errors++; $display("FAIL sat_wide: got %0d want %0d", stall_cnt, exp_stall); end
        out_ready = 1'b1;
        tick;
        checks++; if (out_valid !== 1'b0 || s_stall_cnt !== 2'd3) begin errors++; $display("FAIL sat_end: valid=%b sat=%0d want 0/3", out_valid, s_stall_cnt); end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_freeze;
        test_flush;
        test_reset_midstream;
        test_saturation;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
